// File: rtl/add_req_arbiter.sv
// Arbitrates queued button presses onto one shared accumulator adder.
// Optional `ADD_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority (lowest index).
module add_req_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_DATA = 16,
    parameter int WIDTH    = $clog2(MAX_DATA),
    parameter int PEND_W   = 2
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_i,
    input  logic             acc_ready_i,
    output logic             add_valid_o,
    output logic [WIDTH-1:0] add_amount_o,
    output logic [NREQ-1:0]  grant_o,
    output logic [NREQ-1:0]  overflow_o,
    output logic             busy_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    if (NREQ > WIDTH) begin : g_bad_cfg
        $error("add_req_arbiter: NREQ must not exceed WIDTH");
    end

    // Handshake: an add transfers on a rising clk_25mhz edge where add_valid_o
    // and acc_ready_i are both 1; once raised, add_valid_o, grant_o and
    // add_amount_o hold until that edge. acc_ready_i is ignored while valid is 0.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q [NREQ];
    logic [PEND_W-1:0] pend_d [NREQ];
    logic [NREQ-1:0]   ovf_d;
    logic [NREQ-1:0]   pend_nz;
    logic              handshake;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic [NREQ-1:0]   grant_d;
    logic [WIDTH-1:0]  amount_d;
    logic              valid_d;

    assign handshake = add_valid_o & acc_ready_i;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pend_nz[i] = (pend_q[i] != '0);
        end
    end

    assign busy_o = (state_q == ISSUE) | (|pend_nz);

    // Pending counters: a press and a handshake in the same cycle cancel out,
    // so a saturated counter only loses a press when no handshake drains it.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pend_d[i] = pend_q[i];
            ovf_d[i]  = overflow_o[i];
            if (req_i[i] && !(handshake && grant_o[i])) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 1'b1;
                end
            end else if (!req_i[i] && handshake && grant_o[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                pend_q[i] <= '0;
            end
            overflow_o <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                pend_q[i] <= pend_d[i];
            end
            overflow_o <= ovf_d;
        end
    end

`ifdef ADD_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gidx_q;
    logic [IDX_W-1:0] cand;

    // Search starts just after the last granted requester; iterate the
    // offsets backwards so the nearest candidate is the one kept.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (pend_nz[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            rr_ptr <= IDX_W'(NREQ - 1);
            gidx_q <= '0;
        end else begin
            if (state_q == IDLE && win_found) begin
                gidx_q <= win_idx;
            end
            if (handshake) begin
                rr_ptr <= gidx_q;
            end
        end
    end
`else
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend_nz[i]) begin
                win_idx   = IDX_W'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_o;
        amount_d = add_amount_o;
        valid_d  = add_valid_o;
        case (state_q)
            IDLE: begin
                grant_d  = '0;
                amount_d = '0;
                valid_d  = 1'b0;
                if (win_found) begin
                    grant_d  = NREQ'(1) << win_idx;
                    amount_d = WIDTH'(1) << win_idx;
                    valid_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Clearing after the handshake forces one idle bubble between adds.
                if (acc_ready_i) begin
                    grant_d  = '0;
                    amount_d = '0;
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                grant_d  = '0;
                amount_d = '0;
                valid_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_o      <= '0;
            add_amount_o <= '0;
            add_valid_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_o      <= grant_d;
            add_amount_o <= amount_d;
            add_valid_o  <= valid_d;
        end
    end

endmodule
